// File: rtl/node_endpoint.sv
// Core-side endpoint of a router local link: turns core messages into head+data flits
// and turns inbound flits back into framed payload words for the core.
module node_endpoint #(
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_full_in,
  output logic        link_send,
  output logic [15:0] link_data_out,
  output logic        link_full_out,
  input  logic        link_recv,
  input  logic [15:0] link_data_in,
  input  logic        tx_start,
  input  logic [3:0]  tx_dest_x,
  input  logic [3:0]  tx_dest_y,
  input  logic [3:0]  tx_len,
  output logic        tx_busy,
  input  logic [15:0] tx_data,
  input  logic        tx_data_valid,
  output logic        tx_data_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_first,
  output logic        rx_last,
  output logic        rx_misroute,
  output logic        rx_overflow
);

  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);
  localparam logic [7:0] MY_DEST = {4'(NODE_X), 4'(NODE_Y)};

  // ---------------- transmit side ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_BODY} tx_state_t;

  tx_state_t  tx_state_reg;
  logic [3:0] tx_x_reg;
  logic [3:0] tx_y_reg;
  logic [3:0] tx_len_reg;
  logic [3:0] tx_cnt_reg;

  // Link outputs follow link_full_in combinationally so a stall never lets a flit out.
  always_comb begin
    link_send     = 1'b0;
    link_data_out = 16'h0000;
    tx_data_ready = 1'b0;
    case (tx_state_reg)
      TX_HEAD: begin
        link_send     = !link_full_in;
        link_data_out = {tx_x_reg, tx_y_reg, tx_len_reg, 4'h0};
      end
      TX_BODY: begin
        tx_data_ready = !link_full_in;
        link_send     = tx_data_valid & !link_full_in;
        link_data_out = tx_data;
      end
      default: ;
    endcase
  end

  assign tx_busy = (tx_state_reg != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_x_reg     <= 4'h0;
      tx_y_reg     <= 4'h0;
      tx_len_reg   <= 4'h0;
      tx_cnt_reg   <= 4'h0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_start && (tx_len != 4'h0)) begin
            tx_x_reg     <= tx_dest_x;
            tx_y_reg     <= tx_dest_y;
            tx_len_reg   <= tx_len;
            tx_state_reg <= TX_HEAD;
          end
        end
        TX_HEAD: begin
          if (link_send) begin
            tx_cnt_reg   <= tx_len_reg;
            tx_state_reg <= TX_BODY;
          end
        end
        TX_BODY: begin
          if (link_send) begin
            tx_cnt_reg <= tx_cnt_reg - 4'd1;
            if (tx_cnt_reg == 4'd1) tx_state_reg <= TX_IDLE;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [15:0]      rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_reg;
  logic [PTR_W-1:0] rx_rd_ptr_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;
  logic [15:0]      rx_head_flit;

  assign link_full_out = (rx_cnt_reg == FULL_CNT);
  assign rx_empty      = (rx_cnt_reg == '0);
  assign rx_push       = link_recv & !link_full_out;
  assign rx_head_flit  = rx_mem[rx_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= link_data_in;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_reg <= rx_cnt_reg + 1'b1;
        2'b01:   rx_cnt_reg <= rx_cnt_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- receive framing ----------------
  typedef enum logic {RX_HEAD, RX_BODY} rx_state_t;

  rx_state_t  rx_state_reg;
  logic [3:0] rx_len_reg;
  logic [3:0] rx_idx_reg;
  logic       rx_misroute_reg;
  logic       rx_overflow_reg;

  assign rx_valid    = (rx_state_reg == RX_BODY) & !rx_empty;
  assign rx_data     = rx_valid ? rx_head_flit : 16'h0000;
  assign rx_first    = rx_valid & (rx_idx_reg == 4'd0);
  assign rx_last     = rx_valid & (rx_idx_reg == (rx_len_reg - 4'd1));
  assign rx_pop      = ((rx_state_reg == RX_HEAD) & !rx_empty) | (rx_valid & rx_ready);
  assign rx_misroute = rx_misroute_reg;
  assign rx_overflow = rx_overflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg    <= RX_HEAD;
      rx_len_reg      <= 4'h0;
      rx_idx_reg      <= 4'h0;
      rx_misroute_reg <= 1'b0;
      rx_overflow_reg <= 1'b0;
    end else begin
      if (link_recv && link_full_out) rx_overflow_reg <= 1'b1;
      case (rx_state_reg)
        RX_HEAD: begin
          // Header is consumed internally; zero-length headers never reach the core.
          if (!rx_empty) begin
            rx_len_reg <= rx_head_flit[7:4];
            rx_idx_reg <= 4'h0;
            if (rx_head_flit[15:8] != MY_DEST) rx_misroute_reg <= 1'b1;
            if (rx_head_flit[7:4] != 4'h0) rx_state_reg <= RX_BODY;
          end
        end
        RX_BODY: begin
          if (rx_pop) begin
            rx_idx_reg <= rx_idx_reg + 4'd1;
            if (rx_last) rx_state_reg <= RX_HEAD;
          end
        end
        default: rx_state_reg <= RX_HEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_node_endpoint.sv
// Bench for node_endpoint: flit-level queue model of both link directions,
// directed packets followed by randomized traffic, stalls, overflow and async reset.
module tb_node_endpoint;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_full_in;
  logic        link_send;
  logic [15:0] link_data_out;
  logic        link_full_out;
  logic        link_recv;
  logic [15:0] link_data_in;
  logic        tx_start;
  logic [3:0]  tx_dest_x;
  logic [3:0]  tx_dest_y;
  logic [3:0]  tx_len;
  logic        tx_busy;
  logic [15:0] tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_first;
  logic        rx_last;
  logic        rx_misroute;
  logic        rx_overflow;

  always #5 clk = ~clk;

  node_endpoint #(.NODE_X(1), .NODE_Y(2), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .link_full_in(link_full_in), .link_send(link_send), .link_data_out(link_data_out),
    .link_full_out(link_full_out), .link_recv(link_recv), .link_data_in(link_data_in),
    .tx_start(tx_start), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_first(rx_first), .rx_last(rx_last),
    .rx_misroute(rx_misroute), .rx_overflow(rx_overflow)
  );

  typedef struct packed {
    logic [15:0] val;
    logic        is_head;
    logic        first;
    logic        last;
  } flit_t;

  flit_t       exp_tx[$];    // flits the endpoint still owes the link
  flit_t       rx_fifo[$];   // flits held by the endpoint's inbound buffer
  flit_t       inj[$];       // flits the router side still has to deliver
  logic [15:0] tx_words[$];
  logic [15:0] rx_words[$];
  bit          m_misroute, m_overflow;
  bit          e_send;
  int          checks = 0, failures = 0;

  bit          stall_en = 0, force_full = 0, rand_tx = 0, force_ovf = 0;
  int          ready_pct = 100, send_pct = 100, valid_pct = 100;
  bit          dir_tx = 0;
  logic [3:0]  dir_x, dir_y, dir_len;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void add_rx_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
    flit_t f;
    f.val = {dx, dy, len, 4'h0}; f.is_head = 1'b1; f.first = 1'b0; f.last = 1'b0;
    inj.push_back(f);
    for (int i = 0; i < int'(len); i++) begin
      f.val     = (rx_words.size() != 0) ? rx_words.pop_front() : 16'($urandom);
      f.is_head = 1'b0;
      f.first   = (i == 0);
      f.last    = (i == int'(len) - 1);
      inj.push_back(f);
    end
  endfunction

  function automatic void start_tx(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
    flit_t f;
    f.val = {dx, dy, len, 4'h0}; f.is_head = 1'b1; f.first = 1'b0; f.last = 1'b0;
    exp_tx.push_back(f);
    for (int i = 0; i < int'(len); i++) begin
      f.val     = (tx_words.size() != 0) ? tx_words.pop_front() : 16'($urandom);
      f.is_head = 1'b0;
      f.first   = (i == 0);
      f.last    = (i == int'(len) - 1);
      exp_tx.push_back(f);
    end
  endfunction

  task automatic drive_inputs();
    link_full_in = force_full | (stall_en && ($urandom_range(0, 99) < 30));
    tx_start  = 1'b0;
    tx_dest_x = 4'($urandom);
    tx_dest_y = 4'($urandom);
    tx_len    = 4'($urandom);
    if (dir_tx && exp_tx.size() == 0) begin
      tx_start = 1'b1; tx_dest_x = dir_x; tx_dest_y = dir_y; tx_len = dir_len;
    end else if (rand_tx && $urandom_range(0, 99) < 20) begin
      tx_start = 1'b1;
    end
    tx_data_valid = ($urandom_range(0, 99) < valid_pct);
    tx_data = 16'($urandom);
    if (exp_tx.size() != 0 && tx_data_valid)
      if (!exp_tx[0].is_head) tx_data = exp_tx[0].val;
    link_recv    = 1'b0;
    link_data_in = 16'($urandom);
    if (inj.size() != 0 && (rx_fifo.size() < DEPTH || force_ovf) && $urandom_range(0, 99) < send_pct) begin
      link_recv    = 1'b1;
      link_data_in = inj[0].val;
    end
    rx_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic check_outputs();
    bit busy, front_head, e_valid;
    busy       = (exp_tx.size() != 0);
    front_head = busy ? exp_tx[0].is_head : 1'b0;
    e_send     = busy && !link_full_in && (front_head || tx_data_valid);
    check_eq("tx_busy", 32'(tx_busy), 32'(busy));
    check_eq("link_send", 32'(link_send), 32'(e_send));
    check_eq("tx_data_ready", 32'(tx_data_ready), 32'(busy && !front_head && !link_full_in));
    if (e_send && link_send) check_eq("link_data_out", 32'(link_data_out), 32'(exp_tx[0].val));
    e_valid = (rx_fifo.size() != 0) ? !rx_fifo[0].is_head : 1'b0;
    check_eq("link_full_out", 32'(link_full_out), 32'(rx_fifo.size() == DEPTH));
    check_eq("rx_valid", 32'(rx_valid), 32'(e_valid));
    check_eq("rx_misroute", 32'(rx_misroute), 32'(m_misroute));
    check_eq("rx_overflow", 32'(rx_overflow), 32'(m_overflow));
    if (e_valid && rx_valid) begin
      check_eq("rx_data", 32'(rx_data), 32'(rx_fifo[0].val));
      check_eq("rx_first", 32'(rx_first), 32'(rx_fifo[0].first));
      check_eq("rx_last", 32'(rx_last), 32'(rx_fifo[0].last));
    end
  endtask

  // Applies the effect of the coming clock edge to the model, given the inputs now driven.
  task automatic update_model();
    flit_t f;
    int pre_size;
    if (exp_tx.size() == 0) begin
      if (tx_start && tx_len != 4'h0) begin
        start_tx(tx_dest_x, tx_dest_y, tx_len);
        if (dir_tx) dir_tx = 0;
      end
    end else if (e_send) begin
      f = exp_tx.pop_front();
      if (f.is_head) $display("tx packet head=%04h", f.val);
      else if (f.last) $display("tx packet complete last=%04h", f.val);
    end
    pre_size = rx_fifo.size();
    if (pre_size != 0 && (rx_fifo[0].is_head || rx_ready)) begin
      f = rx_fifo.pop_front();
      if (f.is_head && f.val[15:8] != 8'h12) m_misroute = 1;
      if (f.is_head) $display("rx packet head=%04h", f.val);
      else if (f.last) $display("rx packet complete last=%04h", f.val);
    end
    if (link_recv) begin
      if (pre_size < DEPTH) rx_fifo.push_back(inj.pop_front());
      else m_overflow = 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      #2;
      check_outputs();
      update_model();
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 2000; i++) begin
      if (inj.size() == 0 && rx_fifo.size() == 0 && exp_tx.size() == 0 && !dir_tx) break;
      run(1);
    end
    left = inj.size() + rx_fifo.size() + exp_tx.size() + int'(dir_tx);
    check_eq("drain_timeout", 32'(left), 32'd0);
  endtask

  task automatic queue_tx(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
    dir_x = dx; dir_y = dy; dir_len = len; dir_tx = 1;
  endtask

  initial begin
    rst = 1'b1;
    link_full_in = 0; link_recv = 0; link_data_in = 0; tx_start = 0;
    tx_dest_x = 0; tx_dest_y = 0; tx_len = 0; tx_data = 0; tx_data_valid = 0; rx_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_link_send", 32'(link_send), 0);
    check_eq("rst_link_data_out", 32'(link_data_out), 0);
    check_eq("rst_tx_busy", 32'(tx_busy), 0);
    check_eq("rst_full_out", 32'(link_full_out), 0);
    check_eq("rst_rx_valid", 32'(rx_valid), 0);
    check_eq("rst_rx_flags", 32'({rx_misroute, rx_overflow, rx_first, rx_last}), 0);
    rst = 1'b0;

    // Back-to-back TX packet, and an on-node RX packet.
    tx_words = '{16'h00A1, 16'h00A2, 16'h00A3};
    queue_tx(4'd2, 4'd1, 4'd3);
    rx_words = '{16'hBEEF, 16'hCAFE};
    add_rx_pkt(4'd1, 4'd2, 4'd2);
    drain();

    // Same TX packet with a 3-cycle stall in the body.
    tx_words = '{16'h00A1, 16'h00A2, 16'h00A3};
    queue_tx(4'd2, 4'd1, 4'd3);
    run(3);
    force_full = 1;
    run(3);
    force_full = 0;
    drain();

    // Misrouted single-word packet.
    rx_words = '{16'h0001};
    add_rx_pkt(4'd3, 4'd3, 4'd1);
    drain();

    // Fill the inbound buffer and push into it while full.
    ready_pct = 0; force_ovf = 1;
    add_rx_pkt(4'd1, 4'd2, 4'd6);
    run(10);
    force_ovf = 0; ready_pct = 100;
    drain();

    // Randomized traffic on both directions.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) add_rx_pkt(4'($urandom), 4'($urandom), 4'($urandom));
      else add_rx_pkt(4'd1, 4'd2, 4'($urandom));
    end
    rand_tx = 1; stall_en = 1; valid_pct = 70; ready_pct = 60; send_pct = 60;
    run(3000);
    rand_tx = 0;
    drain();

    // Asynchronous reset with both directions mid-body.
    stall_en = 0; valid_pct = 100; ready_pct = 0; send_pct = 100;
    queue_tx(4'd4, 4'd4, 4'd15);
    add_rx_pkt(4'd1, 4'd2, 4'd15);
    run(6);
    drive_inputs();
    #2;
    check_outputs();
    #1;
    rst = 1'b1;
    #1;
    exp_tx.delete(); rx_fifo.delete(); inj.delete();
    m_misroute = 0; m_overflow = 0; dir_tx = 0;
    check_eq("arst_link_send", 32'(link_send), 0);
    check_eq("arst_tx_busy", 32'(tx_busy), 0);
    check_eq("arst_rx_valid", 32'(rx_valid), 0);
    check_eq("arst_flags", 32'({rx_misroute, rx_overflow, link_full_out}), 0);
    link_recv = 0; tx_start = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_pct = 100;
    tx_words = '{16'h1111, 16'h2222};
    queue_tx(4'd5, 4'd6, 4'd2);
    add_rx_pkt(4'd1, 4'd2, 4'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
